// File: rtl/mealy_pkg.sv
// mealy_pkg
// Shared definitions for the 1101 Mealy detector: state register width
// and the 2-bit state encoding used by the FSM and exposed on the debug
// state port.
package mealy_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S0   = 2'b00,  // no progress
      S1   = 2'b01,  // seen 1
      S11  = 2'b10,  // seen 11
      S110 = 2'b11   // seen 110
   } state_t;

endpackage : mealy_pkg

// File: rtl/mealy_1101_detector_state_reg.sv
// state_reg
// Bank of W rising-edge D flip-flops with a synchronous active-low reset
// to S0 and a load enable. The detector loads it only on valid input bits,
// so gaps in the input stream leave the state untouched.
// Ports:
//   clk      in  1   clock
//   reset_n  in  1   synchronous reset, active low (loads S0)
//   load     in  1   capture d on this edge when high
//   d        in  W   next state
//   q        out W   current state
module state_reg
   import mealy_pkg::*;
#(
   parameter int W = STATE_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] RESET_VALUE = W'(S0);

   logic [W-1:0] q_reg;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               q_reg[gi] <= RESET_VALUE[gi];
            end else if (load) begin
               q_reg[gi] <= d[gi];
            end
         end
      end
   endgenerate

   assign q = q_reg;

endmodule : state_reg

// File: rtl/mealy_1101_detector.sv
// mealy_1101_detector
// Overlapping serial detector for the bit pattern 1101, built as a Mealy
// machine. detect is combinational from the current state and the
// incoming bit; detect_q, a saturating detection counter and a sticky
// flag are registered versions for downstream logic.
// Ports:
//   clk        in  1        clock, rising edge
//   reset_n    in  1        synchronous reset, active low
//   din        in  1        serial data bit
//   din_valid  in  1        qualifies din; FSM advances only when high
//   count_clr  in  1        synchronous clear of count and sticky
//   detect     out 1        high in the cycle the final 1 of 1101 arrives
//   detect_q   out 1        detect delayed by one cycle
//   sticky     out 1        set by the first detect, held until cleared
//   state      out 2        current FSM state (debug)
//   count      out COUNT_W  saturating number of detections
module mealy_1101_detector
   import mealy_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               count_clr,
   output logic               detect,
   output logic               detect_q,
   output logic               sticky,
   output logic [STATE_W-1:0] state,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_next;
   logic               detect_next;
   logic               detect_q_reg;
   logic               sticky_reg;
   logic [COUNT_W-1:0] count_reg;

   // State register; only valid bits advance the machine.
   state_reg #(
      .W (STATE_W)
   ) u_state_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (din_valid),
      .d       (state_next),
      .q       (state_q)
   );

   // Next-state logic. din is only examined under din_valid so an
   // undriven bit during a gap cannot disturb the state.
   always_comb begin
      state_next = state_q;
      if (din_valid) begin
         case (state_t'(state_q))
            S0:      state_next = din ? S1  : S0;
            S1:      state_next = din ? S11 : S0;
            S11:     state_next = din ? S11 : S110;
            S110:    state_next = din ? S1  : S0;  // trailing 1 restarts a prefix
            default: state_next = S0;
         endcase
      end
   end

   // Mealy output; gated by reset_n so it stays low throughout reset.
   always_comb begin
      detect_next = 1'b0;
      if (reset_n && din_valid && (state_t'(state_q) == S110)) begin
         detect_next = din;
      end
   end

   assign detect = detect_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         detect_q_reg <= 1'b0;
      end else begin
         detect_q_reg <= detect_next;
      end
   end

   // Clear beats a coincident detect: that detection is not counted.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_reg  <= '0;
         sticky_reg <= 1'b0;
      end else if (count_clr) begin
         count_reg  <= '0;
         sticky_reg <= 1'b0;
      end else if (detect_next) begin
         sticky_reg <= 1'b1;
         if (count_reg != COUNT_MAX) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign state    = state_q;
   assign detect_q = detect_q_reg;
   assign sticky   = sticky_reg;
   assign count    = count_reg;

endmodule : mealy_1101_detector

// File: tb/tb_mealy_1101_detector.sv
// Testbench for mealy_1101_detector. Stimulus is applied on the falling
// edge; for each cycle the expected outputs are derived from a history of
// valid bits since the last reset and pushed to a queue. A monitor pops
// and compares shortly after the inputs settle.
module tb_mealy_1101_detector;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          din;
   logic          din_valid;
   logic          count_clr;
   logic          detect;
   logic          detect_q;
   logic          sticky;
   logic [1:0]    state;
   logic [CW-1:0] count;

   mealy_1101_detector #(
      .COUNT_W (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .din       (din),
      .din_valid (din_valid),
      .count_clr (count_clr),
      .detect    (detect),
      .detect_q  (detect_q),
      .sticky    (sticky),
      .state     (state),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int det;
      int st;
      int dq;
      int cnt;
      int stk;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cycle_no = 0;

   // Reference model: valid bits seen since the last reset (last few only)
   // plus the registered quantities.
   bit hist[$];
   int m_dq = 0;
   int m_cnt = 0;
   int m_stk = 0;
   bit m_known = 0;

   // Length of the longest tail of the history that is a proper prefix of
   // 1101; with this encoding it is also the state number.
   function automatic int progress();
      int n = hist.size();
      if (n >= 3 && hist[n-3] && hist[n-2] && !hist[n-1]) return 3;
      if (n >= 2 && hist[n-2] && hist[n-1]) return 2;
      if (n >= 1 && hist[n-1]) return 1;
      return 0;
   endfunction

   task automatic check(input string name, input int got, input int want, input int cyc);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
      end
   endtask

   // One clock cycle of stimulus plus the model's prediction for it.
   task automatic send(input bit rn, input bit v, input bit d, input bit clr);
      exp_t e;
      bit   det;
      int   n;
      @(negedge clk);
      cycle_no++;
      reset_n   = rn;
      din_valid = v;
      din       = v ? d : 1'bx;
      count_clr = clr;

      n   = hist.size();
      det = rn && v && d && n >= 3 && hist[n-3] && hist[n-2] && !hist[n-1];

      if (m_known) begin
         e.det = int'(det);
         e.st  = progress();
         e.dq  = m_dq;
         e.cnt = m_cnt;
         e.stk = m_stk;
         e.cyc = cycle_no;
         exp_q.push_back(e);
      end
      $display("cycle %0d: reset_n=%0b valid=%0b din=%0b clr=%0b exp_detect=%0b",
               cycle_no, rn, v, v ? d : 1'b0, clr, det);

      // Post-edge model update.
      if (!rn) begin
         hist.delete();
         m_dq    = 0;
         m_cnt   = 0;
         m_stk   = 0;
         m_known = 1;
      end else begin
         m_dq = int'(det);
         if (clr) begin
            m_cnt = 0;
            m_stk = 0;
         end else if (det) begin
            m_stk = 1;
            if (m_cnt < CMAX) m_cnt++;
         end
         if (v) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
         end
      end
   endtask

   task automatic send_bits(input bit b[]);
      foreach (b[i]) send(1'b1, 1'b1, b[i], 1'b0);
   endtask

   // Monitor: every cycle the DUT presents a full output set.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("detect",   int'(detect),   e.det, e.cyc);
            check("state",    int'(state),    e.st,  e.cyc);
            check("detect_q", int'(detect_q), e.dq,  e.cyc);
            check("count",    int'(count),    e.cnt, e.cyc);
            check("sticky",   int'(sticky),   e.stk, e.cyc);
         end
      end
   end

   initial begin
      bit rn, v, d, clr;
      reset_n   = 1'b0;
      din       = 1'b1;
      din_valid = 1'b1;
      count_clr = 1'b0;

      // Reset held two cycles with active-looking input.
      send(1'b0, 1'b1, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b1, 1'b0);

      // Basic detection followed by idle zeros.
      send_bits('{1, 1, 0, 1, 0, 0});

      // Overlap: two detects, then 11101 detecting once.
      send_bits('{1, 1, 0, 1, 1, 0, 1, 0, 0});
      send_bits('{1, 1, 1, 0, 1, 0});

      // Gap with undriven din: state must hold through the gap.
      send_bits('{1, 1, 0});
      repeat (3) send(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits('{1, 0});

      // Counter already saturated; more detects keep it at max.
      send_bits('{1, 1, 0, 1, 1, 0, 1, 0});

      // Clear coincident with a detect, then one idle cycle.
      send_bits('{1, 1, 0});
      send(1'b1, 1'b1, 1'b1, 1'b1);
      send(1'b1, 1'b1, 1'b0, 1'b0);

      // Mid-pattern reset (din=1 while in S110 must not detect), then restart.
      send_bits('{1, 1, 0});
      send(1'b0, 1'b1, 1'b1, 1'b0);
      send_bits('{1, 1, 0, 1, 0});

      // Randomized traffic with gaps, occasional clears and resets.
      for (int i = 0; i < 2500; i++) begin
         rn  = ($urandom_range(0, 99) != 0);
         v   = ($urandom_range(0, 3) != 0);
         d   = ($urandom_range(0, 9) < 6);
         clr = ($urandom_range(0, 29) == 0);
         send(rn, v, d, clr);
      end

      @(negedge clk);
      #4;
      check("queue_drained", exp_q.size(), 0, cycle_no);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mealy_1101_detector
